// File: rtl/id_ex_pipe_if.sv
// Decode-to-execute bundle: decode-stage instruction fields in, execute-stage
// registered fields plus stall/halt status out.
interface id_ex_pipe_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
);
  logic          de_valid;
  logic [3:0]    de_rs, de_rt, de_rd;
  logic          de_rs_used, de_rt_used;
  logic          de_reg_write, de_mem_read, de_mem_write, de_halt;
  logic [3:0]    de_alu_op;
  logic [DW-1:0] de_rs_data, de_rt_data, de_imm, de_pc;
  logic          flush_de;

  logic [3:0]    rs_de, rt_de, rd_ex;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt;
  logic [3:0]    ex_alu_op;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic          stall_fd;
  logic          halted;
  logic [CW-1:0] stall_count;

  modport master (
    output de_valid, de_rs, de_rt, de_rd, de_rs_used, de_rt_used,
           de_reg_write, de_mem_read, de_mem_write, de_halt, de_alu_op,
           de_rs_data, de_rt_data, de_imm, de_pc, flush_de,
    input  rs_de, rt_de, rd_ex, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_halt, ex_alu_op, ex_rs_data, ex_rt_data,
           ex_imm, ex_pc, stall_fd, halted, stall_count
  );

  modport slave (
    input  de_valid, de_rs, de_rt, de_rd, de_rs_used, de_rt_used,
           de_reg_write, de_mem_read, de_mem_write, de_halt, de_alu_op,
           de_rs_data, de_rt_data, de_imm, de_pc, flush_de,
    output rs_de, rt_de, rd_ex, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_halt, ex_alu_op, ex_rs_data, ex_rt_data,
           ex_imm, ex_pc, stall_fd, halted, stall_count
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion,
// sticky halt latching and a saturating stall-cycle counter.
module id_ex_pipe #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_pipe_if.slave  bus
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e        state_q, state_d;
  logic [3:0]    rs_de_q, rt_de_q, rd_ex_q, alu_op_q;
  logic          valid_q, reg_write_q, mem_read_q, mem_write_q, halt_q;
  logic [DW-1:0] rs_data_q, rt_data_q, imm_q, pc_q;
  logic [CW-1:0] stall_cnt_q;

  logic halted, rs_hit, rt_hit, lu, stall_fd, bubble;

  always_comb begin
    state_d  = state_q;
    halted   = (state_q == StHalted);
    rs_hit   = bus.de_rs_used && (bus.de_rs == rd_ex_q);
    // Store data is forwarded MEM-to-MEM, so a store's rt never stalls.
    rt_hit   = bus.de_rt_used && (bus.de_rt == rd_ex_q) && !bus.de_mem_write;
    lu       = valid_q && mem_read_q && (rd_ex_q != 4'd0) && bus.de_valid && !halted &&
               (rs_hit || rt_hit);
    stall_fd = lu && !bus.flush_de;
    bubble   = lu || bus.flush_de || !bus.de_valid || halted;
    unique case (state_q)
      StRun:    if (!bubble && bus.de_halt) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      rs_de_q     <= '0;
      rt_de_q     <= '0;
      rd_ex_q     <= '0;
      alu_op_q    <= '0;
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      halt_q      <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (bubble) begin
        // Data fields are don't-care in a bubble and simply hold.
        rs_de_q     <= '0;
        rt_de_q     <= '0;
        rd_ex_q     <= '0;
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        halt_q      <= 1'b0;
      end else begin
        rs_de_q     <= bus.de_rs;
        rt_de_q     <= bus.de_rt;
        rd_ex_q     <= bus.de_rd;
        alu_op_q    <= bus.de_alu_op;
        valid_q     <= 1'b1;
        reg_write_q <= bus.de_reg_write;
        mem_read_q  <= bus.de_mem_read;
        mem_write_q <= bus.de_mem_write;
        halt_q      <= bus.de_halt;
        rs_data_q   <= bus.de_rs_data;
        rt_data_q   <= bus.de_rt_data;
        imm_q       <= bus.de_imm;
        pc_q        <= bus.de_pc;
      end
      if (stall_fd && (stall_cnt_q != {CW{1'b1}})) stall_cnt_q <= stall_cnt_q + CW'(1);
    end
  end

  assign bus.rs_de        = rs_de_q;
  assign bus.rt_de        = rt_de_q;
  assign bus.rd_ex        = rd_ex_q;
  assign bus.ex_valid     = valid_q;
  assign bus.ex_reg_write = reg_write_q;
  assign bus.ex_mem_read  = mem_read_q;
  assign bus.ex_mem_write = mem_write_q;
  assign bus.ex_halt      = halt_q;
  assign bus.ex_alu_op    = alu_op_q;
  assign bus.ex_rs_data   = rs_data_q;
  assign bus.ex_rt_data   = rt_data_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_pc        = pc_q;
  assign bus.stall_fd     = stall_fd;
  assign bus.halted       = halted;
  assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: load-use stall, store exemption, r0, flush,
// reset mid-stall, counter saturation (CW = 2) and halt.
module tb_id_ex_pipe;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  id_ex_pipe_if #(.DW(DW), .CW(CW)) bus ();

  id_ex_pipe #(.DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic rsu, input logic rtu,
                       input logic rw, input logic mr, input logic mw, input logic h,
                       input logic fl);
    bus.de_valid     = v;
    bus.de_rs        = rs;
    bus.de_rt        = rt;
    bus.de_rd        = rd;
    bus.de_rs_used   = rsu;
    bus.de_rt_used   = rtu;
    bus.de_reg_write = rw;
    bus.de_mem_read  = mr;
    bus.de_mem_write = mw;
    bus.de_halt      = h;
    bus.de_alu_op    = rd ^ 4'h5;
    bus.de_rs_data   = {12'hA00, rs};
    bus.de_rt_data   = {12'hB00, rt};
    bus.de_imm       = {12'hC00, rd};
    bus.de_pc        = 16'h0100 + {12'h0, rd};
    bus.flush_de     = fl;
    #1;
  endtask

  // drive(valid, rs, rt, rd, rs_used, rt_used, reg_write, mem_read, mem_write, halt, flush)
  initial begin
    logic [CW-1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_rd_ex", bus.rd_ex, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_stall_count", bus.stall_count, 0);
    chk("rst_stall_fd", bus.stall_fd, 0);
    #9 rst_n = 1'b1;

    // Load-use: LW r3 then ADD r6 = r3 + r4
    drive(1'b1, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("lw_rd_ex", bus.rd_ex, 3);
    chk("lw_mem_read", bus.ex_mem_read, 1);
    drive(1'b1, 4'd3, 4'd4, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_stall_fd", bus.stall_fd, 1);
    chk("lu_count_before", bus.stall_count, 0);
    step();
    chk("lu_count_after", bus.stall_count, 1);
    chk("bubble_ex_valid", bus.ex_valid, 0);
    chk("bubble_rd_ex", bus.rd_ex, 0);
    chk("bubble_stall_fd", bus.stall_fd, 0);
    step();
    chk("add_ex_valid", bus.ex_valid, 1);
    chk("add_rs_de", bus.rs_de, 3);
    chk("add_rt_de", bus.rt_de, 4);
    chk("add_rd_ex", bus.rd_ex, 6);
    chk("add_alu_op", bus.ex_alu_op, 4'h6 ^ 4'h5);
    chk("add_rs_data", bus.ex_rs_data, 16'hA003);

    // Store data exemption: LW r5 then SW r5 -> [r2]
    drive(1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd2, 4'd5, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sw_stall_fd", bus.stall_fd, 0);
    step();
    chk("sw_ex_valid", bus.ex_valid, 1);
    chk("sw_rt_de", bus.rt_de, 5);
    chk("sw_mem_write", bus.ex_mem_write, 1);
    chk("sw_count", bus.stall_count, 1);

    // r0 never carries a hazard
    drive(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r0_stall_fd", bus.stall_fd, 0);
    step();
    chk("r0_consumer_valid", bus.ex_valid, 1);
    chk("r0_consumer_rd", bus.rd_ex, 7);

    // Load-use coinciding with flush
    drive(1'b1, 4'd1, 4'd0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd4, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_stall_fd", bus.stall_fd, 0);
    step();
    chk("flush_ex_valid", bus.ex_valid, 0);
    chk("flush_count", bus.stall_count, 1);

    // Reset asserted mid-stall
    drive(1'b1, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd3, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_stall_fd", bus.stall_fd, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall_fd", bus.stall_fd, 0);
    chk("mid_rst_ex_valid", bus.ex_valid, 0);
    chk("mid_rst_mem_read", bus.ex_mem_read, 0);
    chk("mid_rst_rd_ex", bus.rd_ex, 0);
    chk("mid_rst_count", bus.stall_count, 0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_ex_valid", bus.ex_valid, 1);
    chk("post_rst_rs_de", bus.rs_de, 3);
    chk("post_rst_rd_ex", bus.rd_ex, 9);

    // Saturating counter: five stall cycles
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd2, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 4'd0, 4'd1, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("sat_stall_fd_%0d", i), bus.stall_fd, 1);
      step();
      chk($sformatf("sat_count_%0d", i), bus.stall_count, sat_exp[i]);
    end

    // Halt: latched, then every cycle is a bubble
    drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("halt_stall_fd", bus.stall_fd, 0);
    step();
    chk("halt_ex_halt", bus.ex_halt, 1);
    chk("halt_ex_valid", bus.ex_valid, 1);
    chk("halt_halted", bus.halted, 1);
    drive(1'b1, 4'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("halted_ex_valid_1", bus.ex_valid, 0);
    chk("halted_ex_halt", bus.ex_halt, 0);
    chk("halted_sticky", bus.halted, 1);
    drive(1'b1, 4'd2, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halted_stall_fd", bus.stall_fd, 0);
    step();
    chk("halted_ex_valid_2", bus.ex_valid, 0);
    chk("halted_rd_ex", bus.rd_ex, 0);

    rst_n = 1'b0;
    #1;
    chk("final_rst_halted", bus.halted, 0);
    chk("final_rst_ex_valid", bus.ex_valid, 0);
    chk("final_rst_count", bus.stall_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Decode-to-execute pipeline register with load-use stall detection, bubble insertion and halt latching for the 16-register, 16-bit pipelined core. It sits directly upstream of the data hazard/forwarding unit. It captures the decoded instruction each cycle and supplies the execute-stage register IDs, `rs_de`/`rt_de`, that the forwarding logic compares. It detects the one hazard forwarding cannot cover, a load followed by a dependent consumer, and stalls fetch/decode for one cycle.

## Interface
Parameters:
- `DW`, 16: datapath width (operand data, immediate, PC).
- `CW`, 16: stall counter width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `de_valid`  in  1  decode holds a real instruction.
- `de_rs`, `de_rt`, `de_rd`  in  4 each  decode source/destination register IDs.
- `de_rs_used`, `de_rt_used`  in  1 each  instruction actually reads rs/rt.
- `de_reg_write`, `de_mem_read`, `de_mem_write`, `de_halt`  in  1 each  decode control bits.
- `de_alu_op`  in  4  ALU opcode.
- `de_rs_data`, `de_rt_data`, `de_imm`, `de_pc`  in  DW each  operands, immediate, PC+2.
- `flush_de`  in  1  squash the decode instruction (taken branch).
- `rs_de`, `rt_de`, `rd_ex`  out  4 each  registered IDs to the hazard unit and ALU.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_halt`  out  1 each  registered control.
- `ex_alu_op`  out  4  registered ALU opcode.
- `ex_rs_data`, `ex_rt_data`, `ex_imm`, `ex_pc`  out  DW each  registered operands.
- `stall_fd`  out  1  combinational; hold PC and the IF/ID register this cycle.
- `halted`  out  1  registered; a halt has reached execute.
- `stall_count`  out  CW  registered, saturating count of load-use stall cycles.

## Operation
- Load-use hazard `lu` is asserted when all of the following hold:
  - `ex_valid` and `ex_mem_read` are high.
  - `rd_ex` is not 0.
  - `de_valid` is high and `halted` is low.
  - One of these is true: `de_rs_used` with `de_rs == rd_ex`, or `de_rt_used` with `de_rt == rd_ex` and `!de_mem_write`.
- Store data (rt of a store) is excluded from `lu`; it is covered by MEM-to-MEM forwarding.
- `stall_fd = lu & !flush_de`. A flush discards the dependent instruction, so no stall is needed.
- Bubble inserted (next cycle) if `lu`, `flush_de`, `!de_valid`, or `halted`. A bubble forces:
  - `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_halt` to 0.
  - `rd_ex`, `rs_de`, `rt_de` to 0.
  - Data fields hold their previous values (don't-care).
- Otherwise all `de_*` fields are captured unchanged into the `ex_*`/`*_de` registers.
- Register 0 never carries a hazard: `rd_ex == 0` suppresses `lu`. Bubbles carry `rd_ex = 0`, so the hazard unit sees no forwarding source.
- State machine, two states:
  - RUN → HALTED when a valid, non-bubbled `de_halt` is captured. The halt itself propagates with `ex_halt = 1` for that one instruction.
  - HALTED is sticky until reset. `halted = 1`, every subsequent cycle is a bubble, and `stall_fd = 0`.
- `stall_count` increments by 1 on every cycle with `stall_fd = 1` and saturates at all-ones.

## Timing
- Reset (async, `rst_n = 0`): all registered outputs are 0 and the state is RUN. `stall_fd` evaluates to 0 because `ex_valid = 0`.
- Capture latency is 1 cycle: `de_*` at edge N appears on `ex_*` after edge N.
- A load-use stall lasts exactly 1 cycle. After the bubble, the load is in MEM, `ex_mem_read = 0`, `lu` clears, and the held decode instruction is captured next cycle. The hazard unit then resolves the operand through MEM-to-EX forwarding.
- Back-to-back loads with a dependent third instruction: only the immediately preceding load can stall, 1 cycle per dependent pair.
- Simultaneous `lu` and `flush_de`: a bubble is inserted and `stall_fd = 0`.
- Reset asserted mid-stall: the stall is abandoned immediately, with no residual bubble after release.

## Test plan
- Load-use stall:
  - Stimulus: LW r3 in EX (`ex_mem_read = 1`, `rd_ex = 3`), decode ADD with `de_rs = 3`, `de_rs_used = 1`.
  - Required: `stall_fd = 1` and `stall_count` rises 0 → 1.
  - Required next cycle: `ex_valid = 0`, `rd_ex = 0`, `stall_fd = 0`.
  - Required the cycle after: ADD captured with `rs_de = 3`.
- Store data exemption:
  - Stimulus: LW r5 in EX, decode SW with `de_rt = 5`, `de_rt_used = 1`, `de_mem_write = 1`, `de_rs = 2`.
  - Required: `stall_fd = 0`; SW captured next cycle with `rt_de = 5`, `ex_mem_write = 1`.
- r0 and flush:
  - Stimulus: LW r0 with a consumer reading r0.
  - Required: `stall_fd = 0`.
  - Stimulus: a separate LW r4 hazard with `flush_de = 1`.
  - Required: `stall_fd = 0`; next cycle `ex_valid = 0`.
- Halt:
  - Stimulus: valid `de_halt`.
  - Required: next cycle `ex_halt = 1`, `halted = 1`.
  - Required afterwards: every cycle has `ex_valid = 0` regardless of `de_valid`, and `stall_fd = 0`.
- Saturation and reset:
  - Stimulus: with `CW = 2`, force 5 stall cycles.
  - Required: `stall_count` reads 1, 2, 3, 3, 3.
  - Stimulus: assert `rst_n = 0` asynchronously between edges.
  - Required: all outputs 0 immediately, `halted = 0`.
